// File: rtl/apb_ppbuf_reader_pkg.sv
// Shared types and default register map for the APB ping-pong buffer reader.
package apb_ppbuf_reader_pkg;

   localparam logic [31:0] DEF_FLAG_ADDR = 32'h3000_0000;
   localparam logic [31:0] DEF_BUF_BASE  = 32'h3000_6000;
   localparam logic [31:0] DEF_CH_STRIDE = 32'h0000_2000;

   localparam int unsigned DEF_READY_BIT = 12;
   localparam int unsigned DEF_ACK_BIT0  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLAG_RD,
      ST_SELECT,
      ST_DATA_RD,
      ST_PUSH,
      ST_ACK_WR,
      ST_ERROR
   } rd_state_t;

   typedef enum logic [1:0] {
      XF_IDLE,
      XF_SETUP,
      XF_ACCESS
   } xf_state_t;

endpackage

// File: rtl/apb_ppbuf_reader_xfer.sv
// Single APB master transfer: one SETUP cycle, ACCESS until PREADY or timeout.
module apb_master_xfer
   import apb_ppbuf_reader_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              start,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

   xf_state_t       state_q, state_d;
   logic [TO_W-1:0] tcnt_q;
   logic            timeout;

   assign timeout = (state_q == XF_ACCESS) && !PREADY &&
                    (tcnt_q == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge Clk) begin
      if (Rst) state_q <= XF_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         XF_IDLE:   if (start) state_d = XF_SETUP;
         XF_SETUP:  state_d = XF_ACCESS;
         XF_ACCESS: if (PREADY || timeout) state_d = XF_IDLE;
         default:   state_d = XF_IDLE;
      endcase
   end

   always_comb begin
      PSEL    = (state_q != XF_IDLE);
      PENABLE = (state_q == XF_ACCESS);
      done    = (state_q == XF_ACCESS) && (PREADY || timeout);
      err     = (state_q == XF_ACCESS) && ((PREADY && PSLVERR) || timeout);
      rdata   = PRDATA;
   end

   // Address/data/direction are latched at start so they hold through both phases.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         PWRITE <= 1'b0;
         PADDR  <= '0;
         PWDATA <= '0;
         tcnt_q <= '0;
      end else begin
         if (state_q == XF_IDLE && start) begin
            PWRITE <= write;
            PADDR  <= addr;
            PWDATA <= wdata;
         end
         if (state_q == XF_SETUP)       tcnt_q <= '0;
         else if (state_q == XF_ACCESS) tcnt_q <= tcnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/apb_ppbuf_reader.sv
// Interrupt-driven reader: polls the flag register, drains each ready channel
// buffer over APB into a word stream, then acknowledges the channel.
module apb_ppbuf_reader
   import apb_ppbuf_reader_pkg::*;
#(
   parameter int unsigned       DATA_W      = 16,
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       NUM_CH      = 2,
   parameter int unsigned       BLOCK_WORDS = 220,
   parameter logic [ADDR_W-1:0] FLAG_ADDR   = ADDR_W'(DEF_FLAG_ADDR),
   parameter logic [ADDR_W-1:0] BUF_BASE    = ADDR_W'(DEF_BUF_BASE),
   parameter logic [ADDR_W-1:0] CH_STRIDE   = ADDR_W'(DEF_CH_STRIDE),
   parameter int unsigned       READY_BIT   = DEF_READY_BIT,
   parameter int unsigned       ACK_BIT0    = DEF_ACK_BIT0,
   parameter int unsigned       TIMEOUT_CYC = 255,
   localparam int unsigned      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Int,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]   out_ch,
   output logic              out_last,
   output logic              busy,
   output logic              err,
   input  logic              err_clr
);

   localparam int unsigned     WC_W   = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam logic [WC_W-1:0] LAST_W = WC_W'(BLOCK_WORDS - 1);

   rd_state_t         state_q, state_d;
   logic              int_q, int_edge, pend_q, err_q;
   logic [DATA_W-1:0] flag_q, out_data_q, ack_val;
   logic [CH_W-1:0]   ch_q, sel_ch;
   logic [WC_W-1:0]   wcnt_q;
   logic [NUM_CH-1:0] ch_req, ch_bit;
   logic              last_word, flag_ok, more_ch;
   logic              xf_start, xf_write, xf_done, xf_err;
   logic [ADDR_W-1:0] xf_addr;
   logic [DATA_W-1:0] xf_wdata, xf_rdata;

   function automatic logic [ADDR_W-1:0] buf_addr(input logic [CH_W-1:0] c,
                                                  input logic [WC_W-1:0] w);
      return BUF_BASE + ADDR_W'(c) * CH_STRIDE + ADDR_W'(w);
   endfunction

   assign int_edge  = Int & ~int_q;
   assign last_word = (wcnt_q == LAST_W);
   assign flag_ok   = (|(xf_rdata & (DATA_W'(1) << READY_BIT))) && (|xf_rdata[NUM_CH-1:0]);
   assign ch_req    = flag_q[NUM_CH-1:0];
   assign ch_bit    = NUM_CH'(1) << ch_q;
   assign more_ch   = |(ch_req & ~ch_bit);
   assign ack_val   = (flag_q & ~(DATA_W'(1) << READY_BIT) & ~(DATA_W'(1) << ch_q))
                    | (DATA_W'(1) << (ACK_BIT0 + ch_q));

   // Descending scan so the lowest set channel bit wins.
   always_comb begin
      sel_ch = '0;
      for (int unsigned i = NUM_CH; i > 0; i--)
         if (|(ch_req & (NUM_CH'(1) << (i - 1)))) sel_ch = CH_W'(i - 1);
   end

   always_ff @(posedge Clk) begin
      if (Rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (int_edge || pend_q) state_d = ST_FLAG_RD;
         ST_FLAG_RD: if (xf_err)       state_d = ST_ERROR;
                     else if (xf_done) state_d = flag_ok ? ST_SELECT : ST_IDLE;
         ST_SELECT:  state_d = ST_DATA_RD;
         ST_DATA_RD: if (xf_err)       state_d = ST_ERROR;
                     else if (xf_done) state_d = ST_PUSH;
         ST_PUSH:    if (out_ready)    state_d = last_word ? ST_ACK_WR : ST_DATA_RD;
         ST_ACK_WR:  if (xf_err)       state_d = ST_ERROR;
                     else if (xf_done) state_d = more_ch ? ST_SELECT : ST_IDLE;
         ST_ERROR:   if (err_clr)      state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Each transfer is launched on the edge that enters its state, which lets
   // SETUP overlap the first DATA_RD cycle and sustain one word per 3 cycles.
   always_comb begin
      xf_start  = 1'b0;
      xf_write  = 1'b0;
      xf_addr   = FLAG_ADDR;
      xf_wdata  = '0;
      out_valid = (state_q == ST_PUSH);
      out_last  = (state_q == ST_PUSH) && last_word;
      busy      = (state_q != ST_IDLE) && (state_q != ST_ERROR);
      case (state_q)
         ST_IDLE:   xf_start = int_edge | pend_q;
         ST_SELECT: begin
            xf_start = 1'b1;
            xf_addr  = buf_addr(sel_ch, '0);
         end
         ST_PUSH: if (out_ready) begin
            xf_start = 1'b1;
            if (last_word) begin
               xf_write = 1'b1;
               xf_wdata = ack_val;
            end else begin
               xf_addr  = buf_addr(ch_q, wcnt_q + 1'b1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         int_q      <= 1'b0;
         pend_q     <= 1'b0;
         err_q      <= 1'b0;
         flag_q     <= '0;
         ch_q       <= '0;
         wcnt_q     <= '0;
         out_data_q <= '0;
      end else begin
         int_q <= Int;
         if (state_q == ST_IDLE && state_d == ST_FLAG_RD) pend_q <= 1'b0;
         else if (int_edge && busy)                      pend_q <= 1'b1;
         if (xf_err)                            err_q <= 1'b1;
         else if (state_q == ST_ERROR && err_clr) err_q <= 1'b0;
         case (state_q)
            ST_FLAG_RD: if (xf_done && !xf_err) flag_q <= xf_rdata;
            ST_SELECT: begin
               ch_q   <= sel_ch;
               wcnt_q <= '0;
            end
            ST_DATA_RD: if (xf_done && !xf_err) out_data_q <= xf_rdata;
            ST_PUSH:    if (out_ready && !last_word) wcnt_q <= wcnt_q + 1'b1;
            ST_ACK_WR:  if (xf_done && !xf_err) flag_q <= flag_q & ~(DATA_W'(1) << ch_q);
            default: ;
         endcase
      end
   end

   assign out_data = out_data_q;
   assign out_ch   = ch_q;
   assign err      = err_q;

   apb_master_xfer #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_xfer (
      .Clk     (Clk),
      .Rst     (Rst),
      .start   (xf_start),
      .write   (xf_write),
      .addr    (xf_addr),
      .wdata   (xf_wdata),
      .done    (xf_done),
      .err     (xf_err),
      .rdata   (xf_rdata),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR)
   );

endmodule

// File: doc/apb_ppbuf_reader.md
APB_PPBUF_READER -- requirements
Module: apb_ppbuf_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16: APB data width and stream word width.
REQ-002 SHALL have parameter ADDR_W, default 32: APB address width.
REQ-003 SHALL have parameter NUM_CH, default 2 (range 1..8): number of receive buffers (channels).
REQ-004 SHALL have parameter BLOCK_WORDS, default 220: words fetched per buffer.
REQ-005 SHALL have parameter FLAG_ADDR, default 32'h3000_0000: flag register address.
REQ-006 SHALL have parameter BUF_BASE, default 32'h3000_6000: channel 0 buffer base; CH_STRIDE, default 32'h2000: per-channel address offset.
REQ-007 SHALL have parameter READY_BIT, default 12: global-ready flag bit; ACK_BIT0, default 2: channel-0 ack bit, channel c uses ACK_BIT0+c.
REQ-008 SHALL have parameter TIMEOUT_CYC, default 255: maximum wait for PREADY per access.
REQ-009 Clk  in  1  single clock, all logic on rising edge.
REQ-010 Rst  in  1  reset, synchronous, active-high.
REQ-011 Int  in  1  buffer-ready interrupt, level, rising edge starts service.
REQ-012 PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
REQ-013 PADDR  out  ADDR_W; PWDATA  out  DATA_W; PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1.
REQ-014 out_valid out 1, out_ready in 1, out_data out DATA_W, out_ch out clog2(NUM_CH) (min 1), out_last out 1: fetched-word stream.
REQ-015 busy out 1 (service in progress); err out 1 (sticky: timeout or PSLVERR); err_clr in 1.

Function
REQ-016 Each APB transfer SHALL be SETUP (PSEL=1, PENABLE=0) for one cycle, then ACCESS (PSEL=1, PENABLE=1) held until PREADY=1; PADDR/PWRITE/PWDATA stable across both phases; PSEL=0 between transfers.
REQ-017 FSM states: IDLE, FLAG_RD, SELECT, DATA_RD, PUSH, ACK_WR, ERROR.
REQ-018 IDLE -> FLAG_RD on Int rising edge (Int registered once, edge = Int & ~Int_q), or when pend=1.
REQ-019 Int rising edge while busy SHALL set pend (one-deep); pend clears on entry to FLAG_RD.
REQ-020 FLAG_RD: read FLAG_ADDR, capture PRDATA into flag_q; if flag_q[READY_BIT]=0 or flag_q[NUM_CH-1:0]=0 -> IDLE, else -> SELECT.
REQ-021 SELECT: channel = lowest-index set bit of flag_q[NUM_CH-1:0]; word counter = 0; one cycle -> DATA_RD.
REQ-022 DATA_RD: read address BUF_BASE + ch*CH_STRIDE + wcnt (word-indexed, ADDR_W-bit add, wrap ignored); captured word -> PUSH.
REQ-023 PUSH: out_valid=1 with out_data/out_ch held; out_last=1 when wcnt=BLOCK_WORDS-1; on out_valid&out_ready: if last -> ACK_WR else wcnt+1 -> DATA_RD. No APB activity while out_ready=0.
REQ-024 ACK_WR: write FLAG_ADDR with flag_q, bit READY_BIT cleared, bit ch cleared, bit ACK_BIT0+ch set; then clear ch bit in flag_q; if other channel bits remain -> SELECT (re-sets READY_BIT in written value? no: writes keep it cleared), else -> IDLE.
REQ-025 Throughput: one word per 3 cycles with PREADY=1 and out_ready=1 (SETUP, ACCESS, PUSH).
REQ-026 Timeout: counter reset at each SETUP; reaching TIMEOUT_CYC in ACCESS, or PREADY=1 with PSLVERR=1, SHALL end the transfer, set err, -> ERROR.
REQ-027 ERROR: PSEL=PENABLE=0, out_valid=0, busy=0; err_clr=1 -> IDLE (err cleared same edge); pend retained.
REQ-028 busy=1 in every state except IDLE and ERROR.

Reset
REQ-029 Rst=1 at a rising edge SHALL force IDLE; PSEL, PENABLE, PWRITE, out_valid, out_last, busy, err, pend = 0; PADDR, PWDATA, out_data, out_ch, flag_q, counters = 0; Int_q = 0.
REQ-030 Reset mid-transfer SHALL abandon it immediately (PSEL low next cycle); no ack write issued.

Structure
REQ-031 Shared package SHALL hold FSM state enum, default addresses (FLAG_ADDR, BUF_BASE, CH_STRIDE) and flag bit positions.
REQ-032 One sub-module apb_master_xfer SHALL implement REQ-016/REQ-026 (start, write, addr, wdata -> done, rdata, err).

Verification
REQ-033 Flag=16'h1001, PREADY=1, out_ready=1 -> 220 reads 0x3000_6000..0x3000_60DB, out_last on word 219, then write 0x3000_0000 data 16'h0004.
REQ-034 Flag=16'h1003, NUM_CH=2 -> ch0 block, ack 16'h0006 (bit0 clear, bit2 set), then ch1 block at 0x3000_8000, ack 16'h0008.
REQ-035 Flag=16'h0001 (READY_BIT clear) -> one flag read, no data reads, back to IDLE, busy=0.
REQ-036 out_ready=0 for 10 cycles at word 5 -> out_valid/out_data held, PSEL=0 throughout, no word lost or duplicated.
REQ-037 PREADY stuck 0 on word 3 -> err=1 after 255 ACCESS cycles, ERROR; err_clr -> IDLE, err=0.
REQ-038 Int pulse during block; Rst asserted on word 100 -> IDLE next cycle, pend=0, no ack write.
